pipe_hazard_ctrl: RTL



---
 rtl/pipe_ctrl_pkg.sv | 20 ++
 rtl/pipe_hazard_ctrl_stall_mask_enc.sv | 29 ++
 rtl/pipe_hazard_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
// Contents: hazard FSM state enum, default stage indices, enable/stop levels.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    FLUSH_PEND = 2'd1,
    FLUSH_OUT  = 2'd2
  } hz_state_e;

  localparam int STAGE_IF  = 0;
  localparam int STAGE_ID  = 1;
  localparam int STAGE_EX  = 2;
  localparam int STAGE_MEM = 3;
  localparam int STAGE_WB  = 4;

  localparam logic ENABLE = 1'b1;
  localparam logic STOP   = 1'b0;

endpackage

// File: rtl/pipe_hazard_ctrl_stall_mask_enc.sv
// rtl/pipe_hazard_ctrl_stall_mask_enc.sv - stall request to thermometer freeze mask encoder
// Ports:
//   stall_req_i   in  NUM_REQ     per-requester stall level
//   stall_mask_o  out NUM_STAGES  bits [k:0] set, k = highest stage among asserted requesters
module stall_mask_enc
  import pipe_ctrl_pkg::*;
#(
  parameter int                   NUM_STAGES = 5,
  parameter int                   NUM_REQ    = 4,
  parameter logic [4*NUM_REQ-1:0] REQ_STAGE  = 16'h0113
) (
  input  logic [NUM_REQ-1:0]    stall_req_i,
  output logic [NUM_STAGES-1:0] stall_mask_o
);

  // Stage j must hold whenever any asserted requester sits at stage j or later;
  // this yields the thermometer directly without an explicit max search.
  always_comb begin
    stall_mask_o = '0;
    for (int j = 0; j < NUM_STAGES; j++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (stall_req_i[i] && (int'(REQ_STAGE[4*i +: 4]) >= j)) begin
          stall_mask_o[j] = ENABLE;
        end
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hazard controller: stall mask, branch flush, PC redirect, stall watchdog
// Optional feature macro: PIPE_HAZARD_PERF_EN (adds perf_stall_cycles / perf_flush_count outputs)
// Ports:
//   clk                in   core clock
//   rst                in   asynchronous active-low reset
//   stall_req          in   NUM_REQ    per-requester stall level
//   flush_req          in   1          mispredict pulse from FLUSH_STAGE
//   flush_pc           in   XLEN       redirect target, sampled with flush_req
//   stall              out  NUM_STAGES hold per stage (combinational)
//   flush              out  NUM_STAGES bubble per stage (registered)
//   redirect_valid     out  1          load PC with redirect_pc (registered)
//   redirect_pc        out  XLEN       latched redirect target
//   stall_timeout      out  1          sticky watchdog fault
//   perf_stall_cycles  out  32         cycles with any stage held (PIPE_HAZARD_PERF_EN only)
//   perf_flush_count   out  32         flush-out cycles (PIPE_HAZARD_PERF_EN only)
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int                   NUM_STAGES  = STAGE_WB + 1,
  parameter int                   NUM_REQ     = 4,
  parameter logic [4*NUM_REQ-1:0] REQ_STAGE   = 16'h0113,
  parameter int                   FLUSH_STAGE = STAGE_EX,
  parameter int                   XLEN        = 32,
  parameter int                   TIMEOUT     = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    stall_req,
  input  logic                  flush_req,
  input  logic [XLEN-1:0]       flush_pc,
  output logic [NUM_STAGES-1:0] stall,
  output logic [NUM_STAGES-1:0] flush,
  output logic                  redirect_valid,
  output logic [XLEN-1:0]       redirect_pc,
  output logic                  stall_timeout
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0]           perf_stall_cycles,
  output logic [31:0]           perf_flush_count
`endif
);

  localparam int                    CW       = $clog2(TIMEOUT + 1);
  localparam logic [NUM_STAGES-1:0] LOW_MASK = NUM_STAGES'((1 << FLUSH_STAGE) - 1);
  localparam logic [CW-1:0]         TO_VAL   = CW'(TIMEOUT);

  hz_state_e             state_q, state_d;
  logic [XLEN-1:0]       redirect_pc_q, redirect_pc_d;
  logic                  redirect_valid_q, redirect_valid_d;
  logic [NUM_STAGES-1:0] flush_q, flush_d;
  logic [NUM_STAGES-1:0] stall_raw;
  logic [CW-1:0]         wd_cnt_q, wd_cnt_d;
  logic                  timeout_q, timeout_d;

  stall_mask_enc #(
    .NUM_STAGES (NUM_STAGES),
    .NUM_REQ    (NUM_REQ),
    .REQ_STAGE  (REQ_STAGE)
  ) u_stall_mask_enc (
    .stall_req_i  (stall_req),
    .stall_mask_o (stall_raw)
  );

  // Stages younger than the branch are being bubbled during FLUSH_OUT, so
  // holding them would keep wrong-path instructions alive.
  always_comb begin
    stall = stall_raw;
    if (state_q == FLUSH_OUT) begin
      stall = stall_raw & ~LOW_MASK;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Only RUN accepts a flush: a second mispredict while one is in flight is
  // younger than the pending branch and is squashed by it anyway.
  always_comb begin
    state_d          = state_q;
    redirect_pc_d    = redirect_pc_q;
    redirect_valid_d = STOP;
    flush_d          = '0;
    case (state_q)
      RUN: begin
        if (flush_req) begin
          redirect_pc_d = flush_pc;
          state_d       = stall_raw[FLUSH_STAGE] ? FLUSH_PEND : FLUSH_OUT;
        end
      end
      FLUSH_PEND: begin
        if (!stall_raw[FLUSH_STAGE]) begin
          state_d = FLUSH_OUT;
        end
      end
      FLUSH_OUT: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
    // Outputs are registered from the next state so they line up with FLUSH_OUT.
    if (state_d == FLUSH_OUT) begin
      redirect_valid_d = ENABLE;
      flush_d          = LOW_MASK;
    end
  end

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (stall == '0) begin
      wd_cnt_d = '0;
    end else if (wd_cnt_q != TO_VAL) begin
      wd_cnt_d = wd_cnt_q + CW'(1);
    end
    timeout_d = timeout_q | (wd_cnt_d == TO_VAL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redirect_pc_q    <= '0;
      redirect_valid_q <= STOP;
      flush_q          <= '0;
      wd_cnt_q         <= '0;
      timeout_q        <= STOP;
    end else begin
      redirect_pc_q    <= redirect_pc_d;
      redirect_valid_q <= redirect_valid_d;
      flush_q          <= flush_d;
      wd_cnt_q         <= wd_cnt_d;
      timeout_q        <= timeout_d;
    end
  end

  assign flush          = flush_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign stall_timeout  = timeout_q;

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall != '0) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (state_q == FLUSH_OUT) begin
        perf_flush_q <= perf_flush_q + 32'd1;
      end
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flush_count  = perf_flush_q;
`else
  // No performance counters in this build.
`endif

endmodule
